// File: rtl/fetch_sequencer_pkg.sv
// Shared ISA constants and state type for the fetch sequencer.
// Opcode encodings live here so decode and top agree.
package fetch_sequencer_pkg;

  localparam logic [7:0] HALT_OP    = 8'h88;
  localparam logic [4:0] BR_FWD_PFX = 5'b11110;
  localparam logic [4:0] BR_BWD_PFX = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/fetch_sequencer_decode.sv
// Combinational opcode classifier for the fetch sequencer.
// Flags are mutually exclusive by encoding.
module fetch_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [7:0] i_instr,
  output logic       o_is_halt,
  output logic       o_is_br_fwd,
  output logic       o_is_br_bwd
);

  assign o_is_halt   = (i_instr == HALT_OP);
  assign o_is_br_fwd = (i_instr[7:3] == BR_FWD_PFX);
  assign o_is_br_bwd = (i_instr[7:3] == BR_BWD_PFX);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, run/halt FSM and cycle counter.
// ROM is combinational, so every unstalled RUN cycle issues one word.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  start_addr_i,
  output logic [7:0]  rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic [7:0]  instr_o,
  output logic        instr_valid_o,
  input  logic        stall_i,
  output logic [2:0]  br_reg_o,
  input  logic [7:0]  br_dist_i,
  input  logic        flag_i,
  output logic        done_o,
  output logic [15:0] cycles_o
);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_cycles;

  state_t      w_state_nxt;
  logic [7:0]  w_pc_nxt;
  logic [15:0] w_cycles_nxt;
  logic        w_is_halt;
  logic        w_is_fwd;
  logic        w_is_bwd;
  logic        w_run;
  logic [7:0]  w_pc_inc;
  logic [7:0]  w_pc_fwd;
  logic [7:0]  w_pc_bwd;

  fetch_decode u_dec (
    .i_instr     (rom_data_i),
    .o_is_halt   (w_is_halt),
    .o_is_br_fwd (w_is_fwd),
    .o_is_br_bwd (w_is_bwd)
  );

  // 8-bit adders wrap modulo 256 by construction
  assign w_pc_inc = r_pc + 8'd1;
  assign w_pc_fwd = r_pc + br_dist_i;
  assign w_pc_bwd = r_pc - br_dist_i;
  assign w_run    = (r_state == ST_RUN);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_cycles_nxt = r_cycles;
    unique case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start_i) begin
          w_state_nxt  = ST_RUN;
          w_pc_nxt     = start_addr_i;
          w_cycles_nxt = 16'd0;
        end
      end
      ST_RUN: begin
        if (r_cycles != 16'hFFFF) begin
          w_cycles_nxt = r_cycles + 16'd1;
        end
        if (!stall_i) begin
          unique case (1'b1)
            w_is_halt: w_state_nxt = ST_HALTED;
            w_is_fwd:  w_pc_nxt = flag_i ? w_pc_fwd : w_pc_inc;
            w_is_bwd:  w_pc_nxt = flag_i ? w_pc_bwd : w_pc_inc;
            default:   w_pc_nxt = w_pc_inc;
          endcase
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_pc     <= 8'd0;
      r_cycles <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_cycles <= w_cycles_nxt;
    end
  end

  assign rom_addr_o    = r_pc;
  assign instr_o       = w_run ? rom_data_i : 8'h00;
  assign instr_valid_o = w_run && !stall_i;
  assign br_reg_o      = rom_data_i[2:0];
  assign done_o        = (r_state == ST_HALTED);
  assign cycles_o      = r_cycles;

endmodule
